// File: rtl/guard_pkg.sv
// rtl/guard_pkg.sv - shared types for the read/write guards and the recovery sequencer
package guard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISOLATE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RESET   = 3'd3,
        ST_CLEAR   = 3'd4
    } guard_rst_state_e;

    typedef logic [7:0] rst_cnt_t;

    typedef struct packed {
        logic ar_valid;
        logic aw_valid;
        logic r_ready;
        logic b_ready;
    } guard_axi_req_t;

    typedef struct packed {
        logic last;
    } guard_axi_r_t;

    typedef struct packed {
        logic         ar_ready;
        logic         aw_ready;
        logic         r_valid;
        guard_axi_r_t r;
        logic         b_valid;
    } guard_axi_rsp_t;

endpackage

// File: rtl/txn_outstanding_cnt.sv
// rtl/txn_outstanding_cnt.sv - saturating count of AXI transactions awaiting completion
module txn_outstanding_cnt
    import guard_pkg::*;
#(
    parameter int unsigned MaxTxns = 8,
    parameter int unsigned CntW    = $clog2(MaxTxns + 1),
    parameter type         req_t   = guard_axi_req_t,
    parameter type         rsp_t   = guard_axi_rsp_t
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  req_t            req_i,
    input  rsp_t            rsp_i,
    output logic [CntW-1:0] cnt_o
);

    localparam logic [CntW+1:0] MaxVal = (CntW + 2)'(MaxTxns);

    logic            ar_hs, aw_hs, r_hs, b_hs;
    logic [CntW+1:0] up, dn, sum;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign ar_hs = req_i.ar_valid & rsp_i.ar_ready;
    assign aw_hs = req_i.aw_valid & rsp_i.aw_ready;
    assign r_hs  = rsp_i.r_valid & req_i.r_ready & rsp_i.r.last;
    assign b_hs  = rsp_i.b_valid & req_i.b_ready;

    // Net the increments and decrements first, then clamp to [0, MaxTxns].
    always_comb begin
        up = {2'b00, cnt_q} + (CntW + 2)'(ar_hs) + (CntW + 2)'(aw_hs);
        dn = (CntW + 2)'(r_hs) + (CntW + 2)'(b_hs);
        if (up < dn) begin
            sum = '0;
        end else begin
            sum = up - dn;
        end
        if (sum > MaxVal) begin
            sum = MaxVal;
        end
        cnt_d = clr_i ? '0 : sum[CntW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/guard_rst_seq.sv
// rtl/guard_rst_seq.sv - isolate/drain/reset/clear recovery sequencer behind the AXI guards
module guard_rst_seq
    import guard_pkg::*;
#(
    parameter int unsigned MaxTxns     = 8,
    parameter int unsigned DrainCycles = 16,
    parameter int unsigned RstCycles   = 8,
    parameter type         req_t       = guard_axi_req_t,
    parameter type         rsp_t       = guard_axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  req_t     mst_req_i,
    input  rsp_t     slv_rsp_i,
    input  logic     rd_reset_req_i,
    input  logic     wr_reset_req_i,
    output logic     reset_clear_o,
    output logic     isolate_o,
    output logic     slv_rst_no,
    output logic     busy_o,
    output logic     drain_timeout_o,
    output rst_cnt_t rst_cnt_o
);

    localparam int unsigned CntW   = $clog2(MaxTxns + 1);
    localparam int unsigned TmrMax = (DrainCycles > RstCycles) ? DrainCycles : RstCycles;
    localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

    typedef logic [TmrW-1:0] tmr_t;

    localparam tmr_t DrainLast = tmr_t'(DrainCycles - 1);
    localparam tmr_t RstLast   = tmr_t'(RstCycles - 1);

    guard_rst_state_e state_q, state_d;
    tmr_t             tmr_q;
    logic [CntW-1:0]  outstanding;
    logic             timeout_set;
    logic             active_q, slv_rst_n_q, clear_q, timeout_q;
    rst_cnt_t         rst_cnt_q;

    txn_outstanding_cnt #(
        .MaxTxns (MaxTxns),
        .CntW    (CntW),
        .req_t   (req_t),
        .rsp_t   (rsp_t)
    ) u_outstanding (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == ST_RESET),
        .req_i  (mst_req_i),
        .rsp_i  (slv_rsp_i),
        .cnt_o  (outstanding)
    );

    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_reset_req_i || wr_reset_req_i) begin
                    state_d = ST_ISOLATE;
                end
            end
            ST_ISOLATE: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding == '0) begin
                    state_d = ST_RESET;
                end else if (tmr_q == DrainLast) begin
                    state_d     = ST_RESET;
                    timeout_set = 1'b1;
                end
            end
            ST_RESET: begin
                if (tmr_q == RstLast) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!rd_reset_req_i && !wr_reset_req_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One timer serves DRAIN and RESET; it restarts at every state change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= (state_d != state_q) ? '0 : tmr_q + tmr_t'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q    <= 1'b0;
            slv_rst_n_q <= 1'b1;
            clear_q     <= 1'b0;
            timeout_q   <= 1'b0;
            rst_cnt_q   <= '0;
        end else begin
            active_q    <= (state_d != ST_IDLE);
            slv_rst_n_q <= (state_d != ST_RESET);
            clear_q     <= (state_d == ST_CLEAR);
            if (state_d == ST_ISOLATE) begin
                timeout_q <= 1'b0;
            end else if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if ((state_d == ST_RESET) && (state_q != ST_RESET) && (rst_cnt_q != 8'hff)) begin
                rst_cnt_q <= rst_cnt_q + 8'd1;
            end
        end
    end

    assign isolate_o       = active_q;
    assign busy_o          = active_q;
    assign slv_rst_no      = slv_rst_n_q;
    assign reset_clear_o   = clear_q;
    assign drain_timeout_o = timeout_q;
    assign rst_cnt_o       = rst_cnt_q;

endmodule

// File: tb/tb_guard_rst_seq.sv
// tb/tb_guard_rst_seq.sv - self-checking bench for guard_rst_seq
module tb_guard_rst_seq;
    import guard_pkg::*;

    localparam int DRAIN = 16;
    localparam int RSTC  = 8;
    localparam int MAXT  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    guard_axi_req_t req;
    guard_axi_rsp_t rsp;
    logic           rd_req, wr_req;
    logic           reset_clear, isolate, slv_rst_n, busy, drain_to;
    rst_cnt_t       rst_cnt;

    always #5 clk = ~clk;

    guard_rst_seq #(
        .MaxTxns     (MAXT),
        .DrainCycles (DRAIN),
        .RstCycles   (RSTC),
        .req_t       (guard_axi_req_t),
        .rsp_t       (guard_axi_rsp_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .mst_req_i       (req),
        .slv_rsp_i       (rsp),
        .rd_reset_req_i  (rd_req),
        .wr_reset_req_i  (wr_req),
        .reset_clear_o   (reset_clear),
        .isolate_o       (isolate),
        .slv_rst_no      (slv_rst_n),
        .busy_o          (busy),
        .drain_timeout_o (drain_to),
        .rst_cnt_o       (rst_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the recovery sequence as a timeline of cycles.
    logic e_iso, e_busy, e_rstn, e_clr, e_to;
    int   e_cnt;
    int   m_out, out_before;
    bit   m_in_rst, abort, s_any, s_none;

    task automatic tick();
        int inc, dec;
        @(posedge clk);
        if (!rst_n) begin
            abort = 1'b1;
            return;
        end
        s_any      = rd_req | wr_req;
        s_none     = !rd_req && !wr_req;
        out_before = m_out;
        inc = int'(req.ar_valid && rsp.ar_ready) + int'(req.aw_valid && rsp.aw_ready);
        dec = int'(rsp.r_valid && req.r_ready && rsp.r.last) + int'(rsp.b_valid && req.b_ready);
        if (m_in_rst) begin
            m_out = 0;
        end else begin
            m_out = m_out + inc - dec;
            if (m_out < 0) m_out = 0;
            if (m_out > MAXT) m_out = MAXT;
        end
    endtask

    task automatic run_model();
        forever begin
            e_iso = 0; e_busy = 0; e_rstn = 1; e_clr = 0; m_in_rst = 0;
            do begin
                tick(); if (abort) return;
            end while (!s_any);
            e_iso = 1; e_busy = 1; e_to = 0;
            tick(); if (abort) return;
            for (int k = 0; k < DRAIN; k++) begin
                tick(); if (abort) return;
                if (out_before == 0) break;
                if (k == DRAIN - 1) e_to = 1;
            end
            e_rstn = 0; m_in_rst = 1;
            e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
            repeat (RSTC) begin
                tick(); if (abort) return;
            end
            m_in_rst = 0; e_rstn = 1; e_clr = 1;
            do begin
                tick(); if (abort) return;
            end while (!s_none);
        end
    endtask

    initial begin
        e_iso = 0; e_busy = 0; e_rstn = 1; e_clr = 0; e_to = 0; e_cnt = 0;
        m_out = 0; m_in_rst = 0; abort = 0;
        forever begin
            wait (rst_n === 1'b1);
            e_iso = 0; e_busy = 0; e_rstn = 1; e_clr = 0; e_to = 0; e_cnt = 0;
            m_out = 0; m_in_rst = 0; abort = 0;
            run_model();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_isolate", isolate, 0);
            chk("rst_slv_rst_n", slv_rst_n, 1);
            chk("rst_clear", reset_clear, 0);
            chk("rst_busy", busy, 0);
            chk("rst_timeout", drain_to, 0);
            chk("rst_count", rst_cnt, 0);
        end else begin
            chk("model_isolate", isolate, e_iso);
            chk("model_slv_rst_n", slv_rst_n, e_rstn);
            chk("model_clear", reset_clear, e_clr);
            chk("model_busy", busy, e_busy);
            chk("model_timeout", drain_to, e_to);
            chk("model_count", rst_cnt, e_cnt);
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk); n++;
        end
        chk({name, "_idle_reached"}, busy, 0);
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (reset_clear !== 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        chk({name, "_clear_reached"}, reset_clear, 1);
    endtask

    initial begin
        int n, lows, hi;
        rd_req = 0; wr_req = 0; req = '0; rsp = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // idle bus after reset
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_slv_rst_n", slv_rst_n, 1);
        end

        // single read-guard request, no traffic
        rd_req = 1;
        @(negedge clk);
        chk("t2_isolate_t1", isolate, 1);
        @(negedge clk);
        chk("t2_drain_slv_hi", slv_rst_n, 1);
        lows = 0;
        repeat (8) begin
            @(negedge clk);
            if (slv_rst_n === 1'b0) lows++;
        end
        chk("t2_rst_low_cycles", lows, 8);
        @(negedge clk);
        chk("t2_clear_t11", reset_clear, 1);
        chk("t2_slv_released", slv_rst_n, 1);
        chk("t2_count", rst_cnt, 1);
        rd_req = 0;
        wait_idle("t2");

        // three reads outstanding, retired five cycles into DRAIN
        req.ar_valid = 1; rsp.ar_ready = 1;
        repeat (3) @(negedge clk);
        req.ar_valid = 0; rsp.ar_ready = 0;
        wr_req = 1;
        @(negedge clk);
        chk("t3_isolate", isolate, 1);
        repeat (5) @(negedge clk);
        rsp.r_valid = 1; rsp.r.last = 1; req.r_ready = 1;
        repeat (3) @(negedge clk);
        rsp.r_valid = 0; rsp.r.last = 0; req.r_ready = 0;
        n = 8;
        while (slv_rst_n === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        chk("t3_drain_exit", n, 9);
        chk("t3_no_timeout", drain_to, 0);
        wr_req = 0;
        wait_idle("t3");

        // two writes never acknowledged: drain times out
        req.aw_valid = 1; rsp.aw_ready = 1;
        repeat (2) @(negedge clk);
        req.aw_valid = 0; rsp.aw_ready = 0;
        rd_req = 1;
        @(negedge clk);
        chk("t4_isolate", isolate, 1);
        n = 0;
        while (slv_rst_n === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        chk("t4_drain_exit", n, 17);
        chk("t4_timeout", drain_to, 1);
        rd_req = 0;
        wait_idle("t4");
        chk("t4_timeout_sticky", drain_to, 1);

        // both requests, write request lingers into CLEAR, then a re-trigger
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        rd_req = 1; wr_req = 1;
        wait_clear("t5a");
        rd_req = 0;
        hi = 1;
        repeat (4) begin
            @(negedge clk);
            if (reset_clear === 1'b1) hi++;
        end
        wr_req = 0;
        @(negedge clk);
        chk("t5_clear_dwell", hi, 5);
        chk("t5_clear_dropped", reset_clear, 0);
        chk("t5_idle", busy, 0);
        @(negedge clk);
        rd_req = 1;
        wait_clear("t5b");
        chk("t5_count_two", rst_cnt, 2);
        rd_req = 0;
        wait_idle("t5");

        // async reset in the middle of RESET
        rd_req = 1;
        n = 0;
        while (slv_rst_n === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        chk("t6_in_reset", slv_rst_n, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_slv", slv_rst_n, 1);
        chk("t6_async_isolate", isolate, 0);
        chk("t6_async_count", rst_cnt, 0);
        chk("t6_async_busy", busy, 0);
        rd_req = 0;
        @(negedge clk); #2 rst_n = 1'b1;

        // count saturation over 256 recoveries
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            rd_req = 1;
            wait_clear("t7");
            rd_req = 0;
            wait_idle("t7");
            if (i == 254) chk("t7_count_255", rst_cnt, 255);
        end
        chk("t7_count_saturated", rst_cnt, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/guard_rst_seq.md
# guard_rst_seq

Recovery sequencer downstream of the read and write guards. Consumes their latched reset requests and runs a fixed recovery: isolate the slave, drain outstanding transactions with a bounded wait, hold the slave in reset, then acknowledge the guards with `reset_clear`. It also keeps a recovery-event counter and a drain-timeout flag for the register file.

## Interface
- `MaxTxns`, 8: saturation limit of the outstanding-transaction counter; counter width is `$clog2(MaxTxns+1)`.
- `DrainCycles`, 16: maximum cycles spent in DRAIN; must be ≥1.
- `RstCycles`, 8: cycles `slv_rst_no` is held low; must be ≥1.
- `req_t`, logic: AXI request struct; uses `ar_valid`, `aw_valid`, `r_ready`, `b_ready`.
- `rsp_t`, logic: AXI response struct; uses `ar_ready`, `aw_ready`, `r_valid`, `r.last`, `b_valid`.
- `clk_i` in 1: the only clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `mst_req_i` in `req_t`: monitored master request; passive tap.
- `slv_rsp_i` in `rsp_t`: monitored slave response; passive tap.
- `rd_reset_req_i` in 1: latched reset request from the read guard.
- `wr_reset_req_i` in 1: latched reset request from the write guard.
- `reset_clear_o` out 1: acknowledge to both guards.
- `isolate_o` out 1: gates new AR/AW handshakes; the gating is external.
- `slv_rst_no` out 1: active-low slave reset.
- `busy_o` out 1: high in any state other than IDLE.
- `drain_timeout_o` out 1: sticky; the last drain ended with transactions still outstanding.
- `rst_cnt_o` out 8: completed-recovery count; saturates at 255.

## Operation
- Outstanding counter, registered:
  - +1 per AR handshake (`ar_valid&&ar_ready`) and per AW handshake.
  - −1 per R handshake with `last`, and per B handshake.
  - The net change per cycle is −2..+2. It saturates at `MaxTxns` and floors at 0.
  - It keeps counting in every state and is forced to 0 while in RESET.
- FSM states are IDLE, ISOLATE, DRAIN, RESET, CLEAR.
  - IDLE: if `rd_reset_req_i|wr_reset_req_i`, go to ISOLATE.
  - ISOLATE: one cycle. Clears `drain_timeout_o`, loads the drain timer with 0, goes to DRAIN.
  - DRAIN: the timer increments each cycle.
    - If outstanding==0, go to RESET.
    - Otherwise, if timer==`DrainCycles-1`, set `drain_timeout_o` and go to RESET.
    - The outstanding==0 check has priority when both conditions hold.
  - RESET: lasts `RstCycles` cycles. `rst_cnt_o` increments, saturating, on entry. Then go to CLEAR.
  - CLEAR: `reset_clear_o=1`. Stay until both request inputs are low, then go to IDLE.
- Registered outputs per state:
  - `isolate_o=1` in ISOLATE, DRAIN, RESET and CLEAR.
  - `slv_rst_no=0` only in RESET.
  - `reset_clear_o=1` only in CLEAR.
- Requests arriving while not in IDLE are absorbed by the current sequence; there is no queuing.
- If a request is still high when CLEAR exits, IDLE re-triggers on the next cycle.
- Async reset mid-sequence forces IDLE and all output reset values. The count and flag are lost.

## Timing
- Reset values: `isolate_o=0`, `slv_rst_no=1`, `reset_clear_o=0`, `busy_o=0`, `drain_timeout_o=0`, `rst_cnt_o=0`, counter=0.
- All outputs come straight from flops; there are no combinational paths from input to output.
- Request first sampled high at edge t, outstanding==0:
  - ISOLATE in cycle t+1: `isolate_o` and `busy_o` rise.
  - DRAIN in t+2.
  - RESET in t+3..t+2+`RstCycles`.
  - CLEAR from t+3+`RstCycles`.
- Drain worst case: DRAIN lasts exactly `DrainCycles` cycles.
- `reset_clear_o` holds until the guards drop their requests. The guards release one cycle after seeing clear, so the minimum CLEAR dwell is 2 cycles.

## Structure
- Put the state enum `guard_rst_state_e` and the 8-bit count type in `guard_pkg`. The read and write guards import the same package.
- Use one sub-module, `txn_outstanding_cnt`. It holds the handshake decode and the saturating up/down counter, with a synchronous clear input driven in RESET.

## Test plan
- Reset release with idle bus → all outputs at reset values, `busy_o=0`, for 10 cycles.
- `rd_reset_req_i` high at t, no traffic → `isolate_o` rises at t+1. `slv_rst_no` is low for exactly 8 cycles from t+3. `reset_clear_o` rises at t+11. `rst_cnt_o=1`.
- 3 ARs outstanding, then 3 R-last handshakes 5 cycles into DRAIN → RESET is entered on the cycle after the count reaches 0. `drain_timeout_o=0`.
- 2 AWs outstanding, no B → DRAIN lasts 16 cycles, then `drain_timeout_o=1`, then RESET.
- Both requests high; `wr_reset_req_i` stays high 4 cycles into CLEAR → `reset_clear_o` held until both are low, then IDLE. A request re-raised 1 cycle later triggers a second sequence and `rst_cnt_o=2`.
- `rst_ni` pulsed low mid-RESET → `slv_rst_no=1`, `isolate_o=0` and count=0 immediately (async). 256 back-to-back recoveries → `rst_cnt_o` holds 255.
